acondicionador_botones: RTL and testbench

Input-conditioning stage that feeds the chroma control block: it synchronizes and debounces the three raw push-buttons on the board (up, down, mode), converts the up and down presses into single-cycle `UP`/`down` pulses with auto-repeat, and cycles a three-way edit mode that drives the `TC`/`LP` select lines. Its outputs connect directly to the chroma controller's `UP`, `down`, `TC` and `LP` inputs on the same clock.

---
 rtl/acondicionador_botones.sv | 151 +++++++++++++++
 tb/tb_acondicionador_botones.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_botones.sv
// Push-button conditioning: per-button synchronizer and debounce, up/down press
// pulses with auto-repeat, and a three-way edit mode driving TC/LP.
module acondicionador_botones #(
    parameter int DB_COUNT     = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic       UP,
    output logic       down,
    output logic       TC,
    output logic       LP,
    output logic [1:0] modo
);

    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] RD_MAX   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_MAX = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    localparam logic [1:0] MODE_BG   = 2'd0;
    localparam logic [1:0] MODE_LET  = 2'd1;
    localparam logic [1:0] MODE_TONE = 2'd2;

    logic [2:0] raw;
    logic [2:0] est;
    logic [2:0] est_prev_q;
    logic [2:0] rise;
    logic [1:0] rep_fire;
    logic       both;

    assign raw  = {btn_mode, btn_down, btn_up};
    assign rise = est & ~est_prev_q;
    assign both = est[0] & est[1];

    // Bit order everywhere: 0 = up, 1 = down, 2 = mode.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic             s1_q, s2_q;
            logic             est_q, est_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                est_d = est_q;
                cnt_d = '0;
                if (s2_q != est_q) begin
                    if (cnt_q == DB_MAX) begin
                        est_d = ~est_q;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end

            always_ff @(posedge Clk) begin
                if (reset) begin
                    s1_q  <= 1'b0;
                    s2_q  <= 1'b0;
                    est_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    s1_q  <= raw[gi];
                    s2_q  <= s1_q;
                    est_q <= est_d;
                    cnt_q <= cnt_d;
                end
            end

            assign est[gi] = est_q;
        end

        // Hold counter saturates at the delay; a second counter paces the repeats.
        for (gi = 0; gi < 2; gi++) begin : g_rep
            logic [CNT_W-1:0] hold_q, hold_d;
            logic [CNT_W-1:0] rate_q, rate_d;

            always_comb begin
                hold_d = hold_q;
                rate_d = '0;
                if (!est[gi] || both) begin
                    hold_d = '0;
                end else if (hold_q != RD_MAX) begin
                    hold_d = hold_q + ONE;
                end else if (rate_q != RATE_MAX) begin
                    rate_d = rate_q + ONE;
                end
            end

            always_ff @(posedge Clk) begin
                if (reset) begin
                    hold_q <= '0;
                    rate_q <= '0;
                end else begin
                    hold_q <= hold_d;
                    rate_q <= rate_d;
                end
            end

            assign rep_fire[gi] = est[gi] && !both && (hold_q == RD_MAX) && (rate_q == '0);
        end
    endgenerate

    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       tc_q, tc_d;
    logic       lp_q, lp_d;
    logic [1:0] modo_q, modo_d;

    always_comb begin
        modo_d = modo_q;
        if (rise[2]) begin
            modo_d = (modo_q == MODE_TONE) ? MODE_BG : modo_q + 2'd1;
        end
        // A pulse that coincides with a mode change is dropped, not deferred.
        up_d   = (rise[0] | rep_fire[0]) & ~both & ~rise[2];
        down_d = (rise[1] | rep_fire[1]) & ~both & ~rise[2];
        tc_d   = (modo_d == MODE_TONE);
        lp_d   = (modo_d == MODE_LET);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            est_prev_q <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            tc_q       <= 1'b0;
            lp_q       <= 1'b0;
            modo_q     <= MODE_BG;
        end else begin
            est_prev_q <= est;
            up_q       <= up_d;
            down_q     <= down_d;
            tc_q       <= tc_d;
            lp_q       <= lp_d;
            modo_q     <= modo_d;
        end
    end

    assign UP   = up_q;
    assign down = down_q;
    assign TC   = tc_q;
    assign LP   = lp_q;
    assign modo = modo_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with short debounce/repeat constants;
// pulse edges are logged per clock and compared to hand-derived edge numbers.
module tb_acondicionador_botones;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_mode = 1'b0;
    logic       UP, down, TC, LP;
    logic [1:0] modo;

    acondicionador_botones #(
        .DB_COUNT    (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .CNT_W       (26)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_mode(btn_mode),
        .UP      (UP),
        .down    (down),
        .TC      (TC),
        .LP      (LP),
        .modo    (modo)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int up_edges[$];
    int down_edges[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: got %0d", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (UP)   up_edges.push_back(cyc);
            if (down) down_edges.push_back(cyc);
        end
    endtask

    function automatic int up_at(input int i);
        return (up_edges.size() > i) ? up_edges[i] : -1;
    endfunction

    function automatic int down_at(input int i);
        return (down_edges.size() > i) ? down_edges[i] : -1;
    endfunction

    int p;
    int prev_modo;
    int seq[3] = '{1, 2, 0};
    int exp_rep[5];

    initial begin
        // Reset state
        step(3);
        check("rst_UP", int'(UP), 0);
        check("rst_down", int'(down), 0);
        check("rst_TC", int'(TC), 0);
        check("rst_LP", int'(LP), 0);
        check("rst_modo", int'(modo), 0);
        reset = 1'b0;
        step(2);

        // Short glitch rejected
        up_edges.delete();
        btn_up = 1'b1;
        step(3);
        btn_up = 1'b0;
        step(15);
        check("glitch_up_count", up_edges.size(), 0);

        // Clean press: one pulse 7 edges after the press, none on release
        up_edges.delete();
        down_edges.delete();
        p = cyc;
        btn_up = 1'b1;
        step(10);
        btn_up = 1'b0;
        step(20);
        check("press_up_count", up_edges.size(), 1);
        check("press_up_edge", up_at(0), p + 7);
        check("press_down_quiet", down_edges.size(), 0);

        // Bouncing down button then steady high
        down_edges.delete();
        for (int i = 0; i < 12; i++) begin
            btn_down = ((i / 2) % 2 == 0);
            step(1);
        end
        p = cyc;
        btn_down = 1'b1;
        step(10);
        btn_down = 1'b0;
        step(20);
        check("bounce_down_count", down_edges.size(), 1);
        check("bounce_down_edge", down_at(0), p + 7);

        // Auto-repeat: est rises at p+6, repeats at p+27 then every 5
        up_edges.delete();
        p = cyc;
        btn_up = 1'b1;
        step(40);
        btn_up = 1'b0;
        step(30);
        exp_rep = '{p + 7, p + 27, p + 32, p + 37, p + 42};
        check("rep_count", up_edges.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rep_edge%0d", i), up_at(i), exp_rep[i]);
        end

        // Mode cycling 0 -> 1 -> 2 -> 0
        up_edges.delete();
        down_edges.delete();
        prev_modo = 0;
        for (int i = 0; i < 3; i++) begin
            btn_mode = 1'b1;
            step(6);
            check($sformatf("mode%0d_before", i), int'(modo), prev_modo);
            step(1);
            check($sformatf("mode%0d_modo", i), int'(modo), seq[i]);
            check($sformatf("mode%0d_TC", i), int'(TC), (seq[i] == 2) ? 1 : 0);
            check($sformatf("mode%0d_LP", i), int'(LP), (seq[i] == 1) ? 1 : 0);
            prev_modo = seq[i];
            btn_mode = 1'b0;
            step(12);
        end
        check("mode_updown_quiet", up_edges.size() + down_edges.size(), 0);

        // Up and mode together: mode advances, the up pulse is dropped
        up_edges.delete();
        btn_up = 1'b1;
        btn_mode = 1'b1;
        step(7);
        check("coincide_modo", int'(modo), 1);
        step(5);
        btn_up = 1'b0;
        btn_mode = 1'b0;
        step(12);
        check("coincide_up_dropped", up_edges.size(), 0);

        // Both held: silent; after down release, repeat only after full delay
        up_edges.delete();
        down_edges.delete();
        p = cyc;
        btn_up = 1'b1;
        btn_down = 1'b1;
        step(30);
        check("both_quiet", up_edges.size() + down_edges.size(), 0);
        btn_down = 1'b0;
        step(26);
        check("both_no_early_up", up_edges.size(), 0);
        step(1);
        check("both_rep_count", up_edges.size(), 1);
        check("both_rep_edge", up_at(0), p + 57);
        btn_up = 1'b0;
        step(20);
        check("both_down_quiet", down_edges.size(), 0);

        // Reset mid-hold
        up_edges.delete();
        p = cyc;
        btn_up = 1'b1;
        step(10);
        check("rh_press_edge", up_at(0), p + 7);
        reset = 1'b1;
        step(1);
        check("rh_UP", int'(UP), 0);
        check("rh_modo", int'(modo), 0);
        check("rh_LP", int'(LP), 0);
        check("rh_TC", int'(TC), 0);
        step(1);
        up_edges.delete();
        p = cyc;
        reset = 1'b0;
        step(10);
        check("rh_after_count", up_edges.size(), 1);
        check("rh_after_edge", up_at(0), p + 7);
        btn_up = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
